fifo_serial_tx: RTL and testbench

Read-side consumer for the 8-deep, 32-bit synchronous FIFO. It drains the FIFO one word at a time through the FIFO's RD/EMPTY/dataOut port and shifts each word out MSB-first on a framed serial link (clock, data, frame). It sits between the FIFO's read port and the board-level serial output. The block is the reader for the FIFO's writer side.

---
 rtl/fifo_serial_tx_pkg.sv | 16 +
 rtl/fifo_serial_tx_if.sv | 39 +++
 rtl/fifo_serial_tx_bit_tick_gen.sv | 31 +++
 rtl/fifo_serial_tx.sv | 142 ++++++++++++++
 tb/tb_fifo_serial_tx.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_serial_tx_pkg.sv
// Shared types and defaults for the FIFO read-side serial transmitter.
package fifo_serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    SHIFT,
    GAP
  } state_t;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_CLK_DIV = 4;
  localparam int WC_W        = 16;

endpackage

// File: rtl/fifo_serial_tx_if.sv
// FIFO read port plus framed serial link; master is the transmitter side.
interface fifo_serial_tx_if
  import fifo_serial_tx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              fifo_empty;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_data;
  logic              tx_sclk;
  logic              tx_sdata;
  logic              tx_frame;
  logic              busy;
  logic [WC_W-1:0]   word_count;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd,
    output tx_sclk,
    output tx_sdata,
    output tx_frame,
    output busy,
    output word_count
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd,
    input  tx_sclk,
    input  tx_sdata,
    input  tx_frame,
    input  busy,
    input  word_count
  );

endinterface

// File: rtl/fifo_serial_tx_bit_tick_gen.sv
// Bit timing for the serial link: divides Clk by CLK_DIV into bit-start,
// half-bit and bit-end strobes while enabled.
module bit_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic en,
  output logic bit_start,
  output logic half_bit,
  output logic bit_end
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] phase;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      phase <= '0;
    end else if (en) begin
      if (phase == CW'(CLK_DIV - 1)) phase <= '0;
      else                           phase <= phase + 1'b1;
    end
  end

  assign bit_start = en && (phase == '0);
  assign half_bit  = en && (phase == CW'(CLK_DIV / 2 - 1));
  assign bit_end   = en && (phase == CW'(CLK_DIV - 1));

endmodule

// File: rtl/fifo_serial_tx.sv
// Drains the FIFO one word at a time and shifts it out MSB-first on a framed
// serial link. Define FIFO_SERIAL_TX_PARITY_EN to append an even-parity bit.
module fifo_serial_tx
  import fifo_serial_tx_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             EN,
  fifo_serial_tx_if.master bus
);

`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int BCW = $clog2(NBITS);

  state_t            state;
  logic              rd_q;
  logic              sclk_q;
  logic              sdata_q;
  logic              frame_q;
  logic              busy_q;
  logic [WC_W-1:0]   wcount;
  logic [DATA_W-1:0] shreg;
  logic [BCW-1:0]    bit_cnt;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic              parity;
`endif

  logic run;
  logic bit_start;
  logic half_bit;
  logic bit_end;
  logic last_bit;
  logic next_bit;

  assign run = EN && (state == SHIFT || state == GAP);

  bit_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .Clk       (Clk),
    .Rst       (Rst),
    .en        (run),
    .bit_start (bit_start),
    .half_bit  (half_bit),
    .bit_end   (bit_end)
  );

  assign last_bit = (bit_cnt == BCW'(NBITS - 1));
`ifdef FIFO_SERIAL_TX_PARITY_EN
  assign next_bit = (bit_cnt == BCW'(DATA_W - 1)) ? parity : shreg[DATA_W-2];
`else
  assign next_bit = shreg[DATA_W-2];
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      rd_q    <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      wcount  <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else if (EN) begin
      case (state)
        IDLE: begin
          if (!bus.fifo_empty) begin
            state  <= POP;
            rd_q   <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        POP: begin
          state <= LOAD;
          rd_q  <= 1'b0;
        end
        LOAD: begin
          shreg   <= bus.fifo_data;
`ifdef FIFO_SERIAL_TX_PARITY_EN
          parity  <= ^bus.fifo_data;
`endif
          sdata_q <= bus.fifo_data[DATA_W-1];
          frame_q <= 1'b1;
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (half_bit) sclk_q <= 1'b1;
          if (bit_end) begin
            sclk_q <= 1'b0;
            if (last_bit) begin
              state   <= GAP;
              frame_q <= 1'b0;
              sdata_q <= 1'b0;
              bit_cnt <= '0;
              wcount  <= wcount + 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sdata_q <= next_bit;
              shreg   <= {shreg[DATA_W-2:0], 1'b0};
            end
          end
        end
        GAP: begin
          if (bit_end) begin
            if (!bus.fifo_empty) begin
              state <= POP;
              rd_q  <= 1'b1;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A pop deferred by EN=0 stays pending in rd_q and fires when EN returns.
  assign bus.fifo_rd    = rd_q & EN;
  assign bus.tx_sclk    = sclk_q;
  assign bus.tx_sdata   = sdata_q;
  assign bus.tx_frame   = frame_q;
  assign bus.busy       = busy_q;
  assign bus.word_count = wcount;

  a_sclk_low_at_bit_start: assert property (
    @(posedge Clk) disable iff (!Rst) (state == SHIFT && bit_start) |-> !sclk_q
  );

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: FIFO model, per-cycle positional reference model,
// directed scenarios and a randomized phase.
module tb_fifo_serial_tx;

  localparam int W  = 32;
  localparam int CD = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam int NB        = W + 1;
  localparam int FRAME_CYC = 132;
  localparam int PITCH     = 138;
`else
  localparam int NB        = W;
  localparam int FRAME_CYC = 128;
  localparam int PITCH     = 134;
`endif
  localparam int LOW_RUN   = 6;
  localparam int LIMIT     = 3000;

  logic         clk     = 1'b0;
  logic         rst     = 1'b0;
  logic         en      = 1'b1;
  logic         wr_en   = 1'b0;
  logic [W-1:0] wr_data = '0;

  fifo_serial_tx_if #(.DATA_W(W)) bus ();

  fifo_serial_tx #(.DATA_W(W), .CLK_DIV(CD)) dut (
    .Clk (clk),
    .Rst (rst),
    .EN  (en),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // FIFO with dataOut registered on the read strobe
  logic [W-1:0] fq[$];
  bit rd_underflow = 1'b0;
  always @(posedge clk) begin
    if (bus.fifo_rd === 1'b1) begin
      if (fq.size() == 0) rd_underflow = 1'b1;
      else bus.fifo_data <= fq.pop_front();
    end
    if (wr_en) fq.push_back(wr_data);
    bus.fifo_empty <= (fq.size() == 0);
  end

  // Reference model: position within the word's timeline
  // (0 pop, 1 load, then FRAME_CYC serial cycles, then CD gap cycles).
  logic [W-1:0] exp_q[$];
  bit           m_active    = 1'b0;
  int           m_p         = 0;
  logic [W-1:0] m_w         = '0;
  logic [15:0]  m_wc        = '0;
  bit           m_underflow = 1'b0;
  always @(posedge clk) begin
    if (!rst) begin
      m_active = 1'b0;
      m_p      = 0;
      m_wc     = '0;
    end else if (en) begin
      if (!m_active) begin
        if (bus.fifo_empty === 1'b0) begin
          m_active = 1'b1;
          m_p      = 0;
        end
      end else begin
        if (m_p == 0) begin
          if (exp_q.size() == 0) m_underflow = 1'b1;
          else m_w = exp_q.pop_front();
        end
        if (m_p == 1 + FRAME_CYC) m_wc = m_wc + 16'd1;
        if (m_p == 1 + FRAME_CYC + CD) begin
          if (bus.fifo_empty === 1'b0) m_p = 0;
          else m_active = 1'b0;
        end else begin
          m_p = m_p + 1;
        end
      end
    end
    if (wr_en) exp_q.push_back(wr_data);
  end

  function automatic logic bitval(input logic [W-1:0] w, input int k);
    if (k < W) return w[W-1-k];
    return ^w;
  endfunction

  function automatic logic [20:0] model_out();
    logic rd, sc, sd, fr, bz;
    int   k;
    rd = 1'b0; sc = 1'b0; sd = 1'b0; fr = 1'b0; bz = 1'b0;
    if (!rst) return '0;
    if (m_active) begin
      bz = 1'b1;
      rd = (m_p == 0) && en;
      k  = m_p - 2;
      if (k >= 0 && k < FRAME_CYC) begin
        fr = 1'b1;
        sd = bitval(m_w, k / CD);
        sc = (k % CD) >= CD / 2;
      end
    end
    return {rd, sc, sd, fr, bz, m_wc};
  endfunction

  function automatic logic [20:0] out_vec();
    return {bus.fifo_rd, bus.tx_sclk, bus.tx_sdata, bus.tx_frame, bus.busy, bus.word_count};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  // Line monitor: samples tx_sdata on tx_sclk rise, measures frames and pops.
  int          rd_cnt = 0;
  int          rd_cyc_q[$];
  logic [W-1:0] words_q[$];
  int          low_q[$];
  logic [63:0] sreg = '0;
  logic [63:0] last_raw = '0;
  int          nbits = 0, last_nbits = 0, frame_run = 0, low_run = 0, last_len = 0;
  int          frame_fall = 0, busy_fall = 0;
  logic        prev_sclk = 1'b0, prev_frame = 1'b0, prev_busy = 1'b0;

  task automatic clear_mon();
    rd_cnt = 0; rd_cyc_q.delete(); words_q.delete(); low_q.delete();
    last_len = 0; last_nbits = 0; last_raw = '0; low_run = 0;
  endtask

  task automatic monitor();
    logic [63:0] d;
    if (!rst) begin
      sreg = '0; nbits = 0; frame_run = 0; low_run = 0;
      prev_sclk = 1'b0; prev_frame = 1'b0; prev_busy = 1'b0;
      return;
    end
    if (bus.fifo_rd === 1'b1) begin
      rd_cnt++;
      rd_cyc_q.push_back(cyc);
    end
    if (bus.tx_sclk && !prev_sclk) begin
      sreg = {sreg[62:0], bus.tx_sdata};
      nbits++;
    end
    if (bus.tx_frame) begin
      if (!prev_frame) low_q.push_back(low_run);
      low_run = 0;
      frame_run++;
    end else begin
      if (prev_frame) begin
        d          = sreg >> (NB - W);
        last_len   = frame_run;
        last_raw   = sreg;
        last_nbits = nbits;
        words_q.push_back(d[W-1:0]);
        frame_fall = cyc;
        sreg = '0; nbits = 0; frame_run = 0;
      end
      low_run++;
    end
    if (!bus.busy && prev_busy) busy_fall = cyc;
    prev_sclk  = bus.tx_sclk;
    prev_frame = bus.tx_frame;
    prev_busy  = bus.busy;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    cyc++;
    chk($sformatf("cycle%0d {rd,sclk,sdata,frame,busy,count}", cyc), out_vec(), model_out());
    monitor();
  endtask

  task automatic push(input logic [W-1:0] w);
    wr_en = 1'b1; wr_data = w;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    clear_mon();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    step(); step(); step();
    while ((bus.busy || !bus.fifo_empty) && n < LIMIT) begin
      step();
      n++;
    end
    chk({tag, "_idle_timeout"}, n < LIMIT, 1);
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    while (!bus.tx_frame && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_frame_timeout"}, n < 200, 1);
  endtask

  function automatic logic [W-1:0] word_at(input int i);
    if (i < words_q.size()) return words_q[i];
    return 'x;
  endfunction

  function automatic int rd_gap(input int i);
    if (i < rd_cyc_q.size()) return rd_cyc_q[i] - rd_cyc_q[i-1];
    return -1;
  endfunction

  function automatic int low_at(input int i);
    if (i < low_q.size()) return low_q[i];
    return -1;
  endfunction

  initial begin
    logic [20:0] snap;
    int rd_before;
    int pushed;

    // reset state and quiet idle
    step(); step();
    chk("reset_outputs", out_vec(), 21'd0);
    rst = 1'b1;
    clear_mon();
    repeat (20) step();
    chk("idle_busy", bus.busy, 0);
    chk("idle_count", bus.word_count, 0);
    chk("idle_no_rd", rd_cnt, 0);

    // single word
    do_reset();
    push(32'hA5A50F0F);
    wait_idle("single");
    chk("single_rd_pulses", rd_cnt, 1);
    chk("single_frame_len", last_len, FRAME_CYC);
    chk("single_word", word_at(0), 32'hA5A50F0F);
    chk("single_count", bus.word_count, 1);
    chk("single_gap_to_idle", busy_fall - frame_fall, CD);

    // back-to-back words
    do_reset();
    push(32'h00000001);
    push(32'h80000000);
    push(32'hFFFFFFFF);
    wait_idle("b2b");
    chk("b2b_rd_pulses", rd_cnt, 3);
    chk("b2b_pitch1", rd_gap(1), PITCH);
    chk("b2b_pitch2", rd_gap(2), PITCH);
    chk("b2b_low1", low_at(1), LOW_RUN);
    chk("b2b_low2", low_at(2), LOW_RUN);
    chk("b2b_word0", word_at(0), 32'h00000001);
    chk("b2b_word1", word_at(1), 32'h80000000);
    chk("b2b_word2", word_at(2), 32'hFFFFFFFF);
    chk("b2b_count", bus.word_count, 3);

    // EN low for 10 cycles at bit 16
    do_reset();
    push(32'h12345678);
    wait_frame("en");
    repeat (16 * CD) step();
    en = 1'b0;
    snap = out_vec();
    rd_before = rd_cnt;
    repeat (10) step();
    chk("en_hold_outputs", out_vec(), snap);
    chk("en_no_rd", rd_cnt, rd_before);
    en = 1'b1;
    wait_idle("en");
    chk("en_frame_len", last_len, FRAME_CYC + 10);
    chk("en_word", word_at(0), 32'h12345678);
    chk("en_rd_pulses", rd_cnt, 1);
    chk("en_count", bus.word_count, 1);

    // reset mid-word with a second word waiting
    do_reset();
    push(32'hCAFEF00D);
    push(32'h0BADBEEF);
    wait_frame("rst");
    repeat (8 * CD) step();
    rst = 1'b0;
    #1;
    chk("rst_async_outputs", out_vec(), 21'd0);
    step(); step();
    rst = 1'b1;
    clear_mon();
    wait_idle("rst");
    chk("rst_rd_pulses", rd_cnt, 1);
    chk("rst_words", words_q.size(), 1);
    chk("rst_word", word_at(0), 32'h0BADBEEF);
    chk("rst_count", bus.word_count, 1);

`ifdef FIFO_SERIAL_TX_PARITY_EN
    do_reset();
    push(32'h00000001);
    wait_idle("par1");
    chk("par1_nbits", last_nbits, 33);
    chk("par1_parity", last_raw[0], 1);
    chk("par1_word", word_at(0), 32'h00000001);
    push(32'h00000003);
    wait_idle("par3");
    chk("par3_nbits", last_nbits, 33);
    chk("par3_parity", last_raw[0], 0);
    chk("par3_word", word_at(1), 32'h00000003);
`endif

    // randomized traffic and enable gaps
    do_reset();
    pushed = 0;
    for (int i = 0; i < 4000; i++) begin
      step();
      wr_en = 1'b0;
      if (fq.size() < 8 && $urandom_range(0, 29) == 0) begin
        wr_en   = 1'b1;
        wr_data = $urandom;
        pushed++;
      end
      if (en) begin
        if ($urandom_range(0, 39) == 0) en = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        en = 1'b1;
      end
    end
    step();
    wr_en = 1'b0;
    en    = 1'b1;
    wait_idle("random");
    chk("random_count", bus.word_count, pushed % 65536);
    chk("random_words_sent", rd_cnt, pushed);
    chk("rd_while_empty", rd_underflow, 0);
    chk("model_underflow", m_underflow, 0);
    chk("model_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
